retire_trace_queue: RTL

Parametrised successor to the trace monitor's retire capture. It collects retirement events from NUM_CH functional-unit channels (SALU, SIMD1-4, LSU by default) plus issue-halt events. Events are serialised through per-channel holding registers and a fixed-priority arbiter into a DEPTH-entry FIFO, with a sequence stamp on each record. The FIFO drains over a valid/ready port, so a trace sink (DPI bridge or debug port) can apply backpressure without stalling the pipeline. Events that cannot be held are dropped and counted.

---
 rtl/retire_trace_queue.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/retire_trace_queue.sv
// retire_trace_queue: captures retire/halt events from NUM_CH channels plus
// an issue-halt source into per-source holding registers, serialises them
// through a fixed-priority arbiter into a DEPTH-entry FIFO with a sequence
// stamp, and drains over valid/ready. Events that cannot be held are counted.
module retire_trace_queue #(
  parameter int NUM_CH = 6,
  parameter int PC_W   = 32,
  parameter int WFID_W = 6,
  parameter int DEPTH  = 16,
  parameter int CH_W   = $clog2(NUM_CH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         retire_valid,
  input  logic [NUM_CH*PC_W-1:0]    retire_pc,
  input  logic [NUM_CH*WFID_W-1:0]  retire_wfid,
  input  logic                      issue_halt,
  input  logic [WFID_W-1:0]         issue_halt_wfid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH_W-1:0]           out_src,
  output logic [PC_W-1:0]           out_pc,
  output logic [WFID_W-1:0]         out_wfid,
  output logic [15:0]               out_seq,
  output logic [15:0]               drop_count,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int NS = NUM_CH + 1;       // retire channels plus halt source
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Holding registers, one per source
  logic [NS-1:0]     r_pend;
  logic [PC_W-1:0]   r_hpc   [NS];
  logic [WFID_W-1:0] r_hwfid [NS];

  // FIFO storage and control
  logic [CH_W-1:0]   r_mem_src  [DEPTH];
  logic [PC_W-1:0]   r_mem_pc   [DEPTH];
  logic [WFID_W-1:0] r_mem_wfid [DEPTH];
  logic [15:0]       r_mem_seq  [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [15:0]       r_seq;
  logic [15:0]       r_drop;

  // Combinational nets
  logic [NS-1:0]     w_strobe;
  logic [PC_W-1:0]   w_src_pc   [NS];
  logic [WFID_W-1:0] w_src_wfid [NS];
  logic              w_full;
  logic              w_pop;
  logic              w_can_push;
  logic              w_push;
  logic [CH_W-1:0]   w_sel;
  logic [NS-1:0]     w_grant;
  logic [NS-1:0]     w_load;
  logic [NS-1:0]     w_drop;
  logic [16:0]       w_drop_sum;
  logic [15:0]       w_drop_next;
  logic [LW-1:0]     w_level_next;

  // Unpack channel buses into per-source views; halt records carry PC 0
  always_comb begin
    w_strobe = {issue_halt, retire_valid};
    for (int i = 0; i < NUM_CH; i++) begin
      w_src_pc[i]   = retire_pc[i*PC_W +: PC_W];
      w_src_wfid[i] = retire_wfid[i*WFID_W +: WFID_W];
    end
    w_src_pc[NUM_CH]   = '0;
    w_src_wfid[NUM_CH] = issue_halt_wfid;
  end

  // Fixed-priority arbiter: lowest-index pending source wins a FIFO slot
  always_comb begin
    w_full     = (r_level == LW'(DEPTH));
    w_pop      = (r_level != '0) && out_ready;
    w_can_push = !w_full || w_pop;
    w_sel      = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      w_sel = r_pend[i] ? CH_W'(i) : w_sel;
    end
    w_push = (|r_pend) && w_can_push;
    for (int i = 0; i < NS; i++) begin
      w_grant[i] = w_push && (w_sel == CH_W'(i));
    end
  end

  // Capture/drop decision per source and saturating drop accumulation
  always_comb begin
    w_drop_sum = {1'b0, r_drop};
    for (int i = 0; i < NS; i++) begin
      w_load[i]  = w_strobe[i] && (!r_pend[i] || w_grant[i]);
      w_drop[i]  = w_strobe[i] && r_pend[i] && !w_grant[i];
      w_drop_sum = w_drop_sum + 17'(w_drop[i]);
    end
    w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  // Occupancy update: push and pop together leave the level unchanged
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LW'(1);
      2'b01:   w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
  end

  // Holding registers: refill wins over grant-clear on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      for (int i = 0; i < NS; i++) begin
        r_hpc[i]   <= '0;
        r_hwfid[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (w_load[i]) begin
          r_pend[i]  <= 1'b1;
          r_hpc[i]   <= w_src_pc[i];
          r_hwfid[i] <= w_src_wfid[i];
        end else if (w_grant[i]) begin
          r_pend[i]  <= 1'b0;
        end
      end
    end
  end

  // FIFO pointers, level, sequence stamp and drop counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_seq    <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_seq    <= r_seq + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= w_level_next;
      r_drop  <= w_drop_next;
    end
  end

  // FIFO data storage; contents are masked at the output while empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_src[r_wr_ptr]  <= w_sel;
      r_mem_pc[r_wr_ptr]   <= r_hpc[w_sel];
      r_mem_wfid[r_wr_ptr] <= r_hwfid[w_sel];
      r_mem_seq[r_wr_ptr]  <= r_seq;
    end
  end

  assign out_valid  = (r_level != '0);
  assign out_src    = out_valid ? r_mem_src[r_rd_ptr]  : '0;
  assign out_pc     = out_valid ? r_mem_pc[r_rd_ptr]   : '0;
  assign out_wfid   = out_valid ? r_mem_wfid[r_rd_ptr] : '0;
  assign out_seq    = out_valid ? r_mem_seq[r_rd_ptr]  : '0;
  assign drop_count = r_drop;
  assign fifo_level = r_level;

endmodule
